// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types, defaults and helpers for the round-robin bus arbiter.
//   arb_state_t            : arbiter FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES : default grant timeout (cycles without a target ACK)
//   MAX_INIT               : largest supported number of initiators
//   rr_pick()              : index of the first set request at or after a
//                            pointer, wrapping modulo the initiator count
// ----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;
    localparam int MAX_INIT               = 8;

    // Walks the request vector upward starting at ptr and wraps at num.
    // The first hit wins; returns 0 when nothing is requested, so callers
    // must qualify the result with "any request".
    function automatic int rr_pick(input logic [MAX_INIT-1:0] req,
                                   input logic [2:0]          ptr,
                                   input int                  num);
        int   pick;
        int   idx;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_INIT; i++) begin
            if (i < num) begin
                idx = int'(ptr) + i;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!found && req[3'(idx)]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant handshake between the initiator ports and the arbiter.
//   req            : per-initiator level request
//   bus_target_ack : one-cycle ACK from the target ending a transaction
//   gnt            : one-hot grant
//   gnt_id         : index of the granted initiator (bus mux select)
//   gnt_valid      : any grant active
//   bus_busy       : arbiter not idle
//   timeout        : pulse when a grant is revoked by the timeout
//   abort          : pulse when the granted initiator withdrew its request
// Modports: master = arbiter side, slave = initiator/target side.
// ----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NUM_INIT = 2,
    parameter int ID_W     = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
);

    logic [NUM_INIT-1:0] req;
    logic                bus_target_ack;
    logic [NUM_INIT-1:0] gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_valid;
    logic                bus_busy;
    logic                timeout;
    logic                abort;

    modport master (
        input  req, bus_target_ack,
        output gnt, gnt_id, gnt_valid, bus_busy, timeout, abort
    );

    modport slave (
        output req, bus_target_ack,
        input  gnt, gnt_id, gnt_valid, bus_busy, timeout, abort
    );

endinterface

// File: rtl/bus_arbiter_rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selection: chooses the first asserted request at
// or after ptr (with wrap) and reports it both one-hot and as an index.
//   req    : request vector
//   ptr    : round-robin start position
//   onehot : selected request, one-hot (zero when no request)
//   idx    : selected index (0 when no request)
//   any    : at least one request asserted
// ----------------------------------------------------------------------------
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = 2,
    parameter int ID_W     = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
    input  logic [NUM_INIT-1:0] req,
    input  logic [ID_W-1:0]     ptr,
    output logic [NUM_INIT-1:0] onehot,
    output logic [ID_W-1:0]     idx,
    output logic                any
);

    logic [MAX_INIT-1:0] req_ext;
    int                  pick;

    // Widen to the package's fixed search width so one helper serves every
    // NUM_INIT; bits above NUM_INIT are never visited by the search.
    always_comb begin
        req_ext = MAX_INIT'(req);
        pick    = rr_pick(req_ext, 3'(ptr), NUM_INIT);
        any     = |req;
        idx     = ID_W'(pick);
        onehot  = any ? (NUM_INIT'(1) << idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter sharing one serial bus between NUM_INIT initiators.
// A grant is held for a whole transaction and released on a target ACK, an
// initiator abort (request dropped) or a timeout, followed by one turnaround
// cycle. All outputs are registered.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter_if.master (req/ack in, grant/status out)
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT       = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ID_W           = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);

    // A zero timeout still needs a legal (unused) counter width.
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t          state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [NUM_INIT-1:0] gnt_q, gnt_n;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_n;
    logic                gnt_valid_q, busy_q, timeout_q, abort_q;
    logic                timeout_n, abort_n;

    logic [NUM_INIT-1:0] pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;

    rr_priority_picker #(
        .NUM_INIT (NUM_INIT),
        .ID_W     (ID_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, then registered, so req never reaches gnt combinationally.
    // In GRANT the exit priority is ACK, then request drop, then timeout.
    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        cnt_n     = '0;
        gnt_n     = '0;
        gnt_id_n  = '0;
        timeout_n = 1'b0;
        abort_n   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_n  = ARB_GRANT;
                    gnt_n    = pick_onehot;
                    gnt_id_n = pick_idx;
                    rr_ptr_n = (pick_idx == ID_W'(NUM_INIT - 1)) ? '0 : pick_idx + ID_W'(1);
                end
            end
            ARB_GRANT: begin
                gnt_id_n = gnt_id_q;
                cnt_n    = (cnt == '1) ? cnt : cnt + CNT_W'(1);
                if (bus.bus_target_ack) begin
                    state_n = ARB_RELEASE;
                end else if (!bus.req[gnt_id_q]) begin
                    state_n = ARB_RELEASE;
                    abort_n = 1'b1;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    state_n   = ARB_RELEASE;
                    timeout_n = 1'b1;
                end else begin
                    gnt_n = gnt_q;
                end
            end
            ARB_RELEASE: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers. Reset drops the grant
    // immediately with no release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            cnt         <= cnt_n;
            gnt_q       <= gnt_n;
            gnt_id_q    <= gnt_id_n;
            gnt_valid_q <= |gnt_n;
            busy_q      <= (state_n != ARB_IDLE);
            timeout_q   <= timeout_n;
            abort_q     <= abort_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.bus_busy  = busy_q;
    assign bus.timeout   = timeout_q;
    assign bus.abort     = abort_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares the single serial bus between NUM_INIT initiator ports. Only one initiator at a time may drive bus_data_in, bus_data_in_valid, bus_mode and target_rw toward target_port.
The grant is held for one complete transaction. It is released on a target ACK, an initiator abort, or a timeout, followed by a one-cycle turnaround.
The block sits between the initiator ports and the bus multiplexer; gnt_id drives the mux select.

Parameters:
NUM_INIT, 2, number of requesting initiators (2..8)
TIMEOUT_CYCLES, 256, maximum cycles a grant may be held without a target ACK; 0 disables the timeout
ID_W, (NUM_INIT>1 ? $clog2(NUM_INIT) : 1), width of gnt_id; derived, must not be overridden

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_INIT  per-initiator bus request, level; held high until the transaction ends
bus_target_ack  input  1  target ACK pass-through from target_port; one-cycle pulse ending a transaction
gnt  output  NUM_INIT  one-hot grant to initiators; all zero when no grant
gnt_id  output  ID_W  index of the granted initiator; bus mux select, held while bus_busy
gnt_valid  output  1  high while any grant is active (OR of gnt)
bus_busy  output  1  high in GRANT and RELEASE states; low only in IDLE
timeout  output  1  one-cycle pulse when a grant is revoked by the timeout
abort  output  1  one-cycle pulse when the granted initiator drops req before the ACK

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs 0; state IDLE
  - round-robin pointer rr_ptr = 0; timeout counter = 0
  - reset mid-transaction drops gnt at once, with no release cycle
- States are IDLE, GRANT and RELEASE.
- IDLE:
  - if req != 0, select the first asserted req at or after rr_ptr, searching upward with wrap modulo NUM_INIT
  - next cycle: state GRANT; gnt[sel] = 1, gnt_id = sel, gnt_valid = 1, bus_busy = 1
  - rr_ptr = (sel+1) mod NUM_INIT
  - req->gnt latency is exactly 1 cycle
  - if req == 0, stay in IDLE with all outputs 0
- GRANT:
  - the counter increments every cycle
  - priority of exit events in the same cycle: bus_target_ack > req[gnt_id] drop > timeout
  - bus_target_ack = 1: go to RELEASE next cycle (normal completion; no pulse)
  - req[gnt_id] = 0 without ACK: go to RELEASE and pulse abort in that next cycle
  - TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without ACK: go to RELEASE and pulse timeout in that next cycle
  - an ACK on the same cycle as counter expiry is a normal completion, with no timeout pulse
  - requests from non-granted initiators are ignored; no preemption
- RELEASE:
  - exactly 1 cycle: gnt = 0, gnt_valid = 0, bus_busy = 1, gnt_id keeps its last value, counter cleared
  - always returns to IDLE
  - back-to-back minimum: ACK at cycle n, next gnt at cycle n+3
- bus_target_ack in IDLE or RELEASE is ignored.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- With NUM_INIT = 1: the rr_ptr logic reduces to a constant and gnt_id stays 0.
- All outputs are registered; there is no combinational path from req to gnt.

Decomposition:
- Package bus_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT, ARB_RELEASE}
  - localparam default TIMEOUT_CYCLES
  - function rr_pick(req, ptr): returns the index of the first set bit at or after ptr, with wrap
- One natural sub-module, rr_priority_picker: combinational masked-priority select that produces the one-hot selection and its index from req and rr_ptr.
  - The FSM and counter stay in bus_arbiter.

Test Plan:
- Single requester: req=2'b01 at cycle 0 -> gnt=01, gnt_id=0 at cycle 1; ACK at cycle 30 -> gnt=00 at cycle 31, bus_busy=0 at cycle 32.
- Simultaneous requests after reset: req=2'b11 -> initiator 0 granted first; after its ACK and release, initiator 1 granted with gnt_id=1; then initiator 0 again with req still 11 (strict alternation over 4 transactions).
- Abort: initiator 1 granted, drops req at cycle 10 of the grant -> abort pulses for 1 cycle, gnt cleared, rr_ptr still advanced past 1.
- Timeout: TIMEOUT_CYCLES=16, no ACK -> gnt held exactly 16 cycles; timeout pulses once; the next requester is granted 2 cycles later.
- ACK on the expiry cycle with TIMEOUT_CYCLES=16 -> normal release, timeout stays 0.
- Reset mid-grant: assert rst_n=0 while gnt=10 -> gnt=00, bus_busy=0 immediately (before the next edge); after release, req=11 -> initiator 0 granted.
